// File: rtl/car_lane_resolver.sv
// car_lane_resolver: lane position, move latching, game-step tick, post-crash immunity and lives for Car Dash
module car_lane_resolver #(
   parameter int LANES        = 6,
   parameter int TICK_DIV     = 50000000,
   parameter int IMMUNE_TICKS = 3,
   parameter int LIVES        = 3,
   parameter int START_POS    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [LANES-1:0]         next_row,
   input  logic [LANES-1:0]         head_row,
   input  logic [1:0]               move_req,
   input  logic                     restart,
   output logic [$clog2(LANES)-1:0] position,
   output logic                     step,
   output logic                     crash,
   output logic                     immune,
   output logic [3:0]               lives_left,
   output logic                     game_over
);
   localparam int PW = $clog2(LANES);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = $clog2(IMMUNE_TICKS + 1);
   localparam logic [PW-1:0] LEFT_EDGE = PW'(LANES - 1);
   typedef enum logic [1:0] {ALIVE, IMMUNE, GAME_OVER} state_t;
   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [IW-1:0]   imm_q, imm_d;
   logic [1:0]      latch_q, latch_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [3:0]      lives_q, lives_d;
   logic            step_q, step_d;
   logic            crash_q, crash_d;
   logic            step_cycle, req_valid, hit;
   logic [1:0]      move;
   logic [PW-1:0]   target;
   // Decode this step's effective move, the lane it leads to, and whether that lane is blocked
   always_comb begin
      step_cycle = tick_q == TW'(TICK_DIV - 1);
      req_valid  = move_req == 2'b10 || move_req == 2'b01;
      move       = (latch_q != 2'b00) ? latch_q : req_valid ? move_req : 2'b00;
      target     = (move == 2'b10 && pos_q != LEFT_EDGE) ? pos_q + PW'(1)
                 : (move == 2'b01 && pos_q != '0) ? pos_q - PW'(1) : pos_q;
      hit        = (target == pos_q) ? next_row[pos_q] : next_row[target] | head_row[target];
   end
   // Next-state: divider, latch, and the per-step resolution of ALIVE / IMMUNE / GAME_OVER
   always_comb begin
      state_d = state_q;
      tick_d  = step_cycle ? '0 : tick_q + TW'(1);
      imm_d   = imm_q;
      latch_d = latch_q;
      pos_d   = pos_q;
      lives_d = lives_q;
      step_d  = 1'b0;
      crash_d = 1'b0;
      if (state_q == GAME_OVER) begin
         if (restart) begin
            state_d = ALIVE;
            lives_d = 4'(LIVES);
            pos_d   = PW'(START_POS);
            tick_d  = '0;
            latch_d = 2'b00;
         end
      end else if (step_cycle) begin
         step_d  = 1'b1;
         latch_d = 2'b00;
         if (state_q == IMMUNE) begin
            pos_d   = target;
            imm_d   = imm_q - IW'(1);
            state_d = (imm_q == IW'(1)) ? ALIVE : IMMUNE;
         end else if (hit) begin
            crash_d = 1'b1;
            lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : lives_q;
            state_d = (lives_q <= 4'd1) ? GAME_OVER : IMMUNE;
            imm_d   = IW'(IMMUNE_TICKS);
         end else begin
            pos_d = target;
         end
      end else if (latch_q == 2'b00 && req_valid) begin
         latch_d = move_req;
      end
   end
   // State registers with asynchronous reset to the start-of-game values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ALIVE;
         tick_q  <= '0;
         imm_q   <= '0;
         latch_q <= 2'b00;
         pos_q   <= PW'(START_POS);
         lives_q <= 4'(LIVES);
         step_q  <= 1'b0;
         crash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         imm_q   <= imm_d;
         latch_q <= latch_d;
         pos_q   <= pos_d;
         lives_q <= lives_d;
         step_q  <= step_d;
         crash_q <= crash_d;
      end
   end
   assign position   = pos_q;
   assign step       = step_q;
   assign crash      = crash_q;
   assign immune     = state_q == IMMUNE;
   assign lives_left = lives_q;
   assign game_over  = state_q == GAME_OVER;
endmodule

// File: tb/tb_car_lane_resolver.sv
// tb_car_lane_resolver: random and directed stimulus checked cycle by cycle against a behavioural model
module tb_car_lane_resolver;
   localparam int LANES = 6, TICK_DIV = 4, IMMUNE_TICKS = 3, LIVES = 3, START_POS = 2;
   localparam int M_ALIVE = 0, M_IMM = 1, M_OVER = 2;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] next_row = '0;
   logic [5:0] head_row = '0;
   logic [1:0] move_req = '0;
   logic       restart = 1'b0;
   logic [2:0] position;
   logic       step, crash, immune, game_over;
   logic [3:0] lives_left;
   int checks = 0, errors = 0;
   int m_pos, m_lives, m_cnt, m_pend, m_left, m_mode;
   bit m_step, m_crash;

   car_lane_resolver #(.LANES(LANES), .TICK_DIV(TICK_DIV), .IMMUNE_TICKS(IMMUNE_TICKS),
                       .LIVES(LIVES), .START_POS(START_POS)) dut (
      .clk(clk), .rst_n(rst_n), .next_row(next_row), .head_row(head_row),
      .move_req(move_req), .restart(restart), .position(position), .step(step),
      .crash(crash), .immune(immune), .lives_left(lives_left), .game_over(game_over));

   always #5 clk = ~clk;

   // What the coming clock edge must do, computed from the game rules
   function automatic void model_step();
      int mv, tgt;
      bit hit, sc;
      m_step = 0;
      m_crash = 0;
      if (!rst_n) begin
         m_pos = START_POS; m_lives = LIVES; m_mode = M_ALIVE; m_cnt = 0; m_pend = 0; m_left = 0;
         return;
      end
      if (m_mode == M_OVER && restart) begin
         m_mode = M_ALIVE; m_lives = LIVES; m_pos = START_POS; m_cnt = 0; m_pend = 0;
         return;
      end
      sc = (m_cnt == TICK_DIV - 1);
      m_cnt = (m_cnt + 1) % TICK_DIV;
      if (m_mode == M_OVER) return;
      if (!sc) begin
         if (m_pend == 0 && (move_req == 2'd1 || move_req == 2'd2)) m_pend = int'(move_req);
         return;
      end
      mv = (m_pend != 0) ? m_pend : (move_req == 2'd1 || move_req == 2'd2) ? int'(move_req) : 0;
      m_pend = 0;
      m_step = 1;
      if (mv == 2) tgt = (m_pos + 1 < LANES) ? m_pos + 1 : m_pos;
      else if (mv == 1) tgt = (m_pos > 0) ? m_pos - 1 : m_pos;
      else tgt = m_pos;
      hit = (tgt == m_pos) ? next_row[m_pos] : (next_row[tgt] | head_row[tgt]);
      if (m_mode == M_IMM) begin
         m_pos = tgt;
         m_left = m_left - 1;
         if (m_left == 0) m_mode = M_ALIVE;
      end else if (hit) begin
         m_crash = 1;
         m_lives = m_lives - 1;
         m_mode = (m_lives == 0) ? M_OVER : M_IMM;
         m_left = IMMUNE_TICKS;
      end else begin
         m_pos = tgt;
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("position", int'(position), m_pos);
      chk("step", int'(step), int'(m_step));
      chk("crash", int'(crash), int'(m_crash));
      chk("immune", int'(immune), int'(m_mode == M_IMM));
      chk("lives_left", int'(lives_left), m_lives);
      chk("game_over", int'(game_over), int'(m_mode == M_OVER));
   endtask

   task automatic cyc(input logic [1:0] mr, input logic [5:0] nr, input logic [5:0] hr, input logic rs);
      move_req = mr; next_row = nr; head_row = hr; restart = rs;
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_step(input logic [1:0] mr, input logic [5:0] nr, input logic [5:0] hr);
      int n = 0;
      do begin
         cyc(mr, nr, hr, 1'b0);
         n++;
      end while (!m_step && n < 2 * TICK_DIV);
      if (!m_step) chk("step_timeout", 0, 1);
   endtask

   initial begin
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      cyc(2'b00, 6'h00, 6'h00, 1'b0);
      cyc(2'b00, 6'h00, 6'h00, 1'b0);
      chk("rst_pos", int'(position), 2);
      chk("rst_lives", int'(lives_left), 3);
      chk("rst_game_over", int'(game_over), 0);
      rst_n = 1'b1;
      // free drive: one-cycle left pulse, then idle
      cyc(2'b10, 6'h00, 6'h00, 1'b0);
      do_step(2'b00, 6'h00, 6'h00);
      chk("free_pos1", int'(position), 3);
      n = 0;
      do begin cyc(2'b00, 6'h00, 6'h00, 1'b0); n++; end while (!step && n < 2 * TICK_DIV);
      chk("step_period", n, 4);
      chk("free_pos2", int'(position), 3);
      // drive to the left edge and crash into it
      do_step(2'b10, 6'h00, 6'h00);
      do_step(2'b10, 6'h00, 6'h00);
      chk("edge_pos", int'(position), 5);
      do_step(2'b10, 6'b100000, 6'h00);
      chk("edge_crash", int'(crash), 1);
      chk("edge_lives", int'(lives_left), 2);
      chk("edge_hold", int'(position), 5);
      chk("edge_immune", int'(immune), 1);
      // immunity window against a fully blocked road
      for (int i = 0; i < 3; i++) begin
         do_step(2'b00, 6'h3f, 6'h00);
         chk("imm_no_crash", int'(crash), 0);
      end
      chk("imm_dropped", int'(immune), 0);
      do_step(2'b00, 6'h3f, 6'h00);
      chk("imm_crash4", int'(crash), 1);
      chk("imm_lives", int'(lives_left), 1);
      for (int i = 0; i < 3; i++) do_step(2'b01, 6'h00, 6'h00);
      chk("back_pos", int'(position), 2);
      chk("back_alive", int'(immune), 0);
      // side collision through head_row costs the last life
      do_step(2'b01, 6'h00, 6'b000010);
      chk("side_crash", int'(crash), 1);
      chk("side_hold", int'(position), 2);
      chk("over_flag", int'(game_over), 1);
      chk("over_lives", int'(lives_left), 0);
      n = 0;
      for (int i = 0; i < 3 * TICK_DIV; i++) begin
         cyc(2'b10, 6'h00, 6'h00, 1'b0);
         n += int'(step);
      end
      chk("over_no_step", n, 0);
      chk("over_frozen", int'(position), 2);
      // restart and first step timing
      cyc(2'b00, 6'h00, 6'h00, 1'b1);
      chk("rs_game_over", int'(game_over), 0);
      chk("rs_lives", int'(lives_left), 3);
      chk("rs_pos", int'(position), 2);
      n = 0;
      do begin cyc(2'b00, 6'h00, 6'h00, 1'b0); n++; end while (!step && n < 2 * TICK_DIV);
      chk("rs_first_step", n, TICK_DIV);
      do_step(2'b01, 6'h00, 6'h00);
      chk("side_free_pos", int'(position), 1);
      chk("side_free_crash", int'(crash), 0);
      // first request wins within a period
      cyc(2'b01, 6'h00, 6'h00, 1'b0);
      cyc(2'b10, 6'h00, 6'h00, 1'b0);
      do_step(2'b00, 6'h00, 6'h00);
      chk("arb_pos", int'(position), 0);
      // reset mid-period with a latched move
      cyc(2'b10, 6'h00, 6'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_pos", int'(position), 2);
      chk("arst_lives", int'(lives_left), 3);
      chk("arst_step", int'(step), 0);
      chk("arst_immune", int'(immune), 0);
      chk("arst_game_over", int'(game_over), 0);
      cyc(2'b00, 6'h00, 6'h00, 1'b0);
      rst_n = 1'b1;
      do_step(2'b00, 6'h00, 6'h00);
      chk("arst_latch_clear", int'(position), 2);
      // randomized play
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         cyc(2'($urandom), 6'($urandom & $urandom & $urandom), 6'($urandom & $urandom & $urandom),
             $urandom_range(0, 7) == 0);
      end
      rst_n = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/car_lane_resolver.md
Name: car_lane_resolver

Overview:
- Parametrised, self-contained car movement and collision resolver for the Car Dash game.
- Owns the car's lane position, move-request latching, the game-step tick divider, the post-crash immunity window, and the lives count.
- Sits between the button debouncers and the road/row generator.
- Drives the position to the display and a game-over flag to the top-level controller.

Parameters:
LANES, 6, number of lanes; must be >= 2; lane 0 is rightmost, lane LANES-1 is leftmost
TICK_DIV, 50000000, clk cycles per game step (0.5 s at 100 MHz)
IMMUNE_TICKS, 3, game steps of immunity after a crash; must be >= 1
LIVES, 3, lives at reset/restart; must be 1..15
START_POS, 2, lane at reset/restart; must be < LANES

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
next_row  in  LANES  obstacle bits of the row the car enters next step; 1 = blocked
head_row  in  LANES  obstacle bits of the row the car currently occupies
move_req  in  2  00 none/up, 10 left, 01 right, 11 ignored
restart  in  1  synchronous restart; honoured only in GAME_OVER
position  out  $clog2(LANES)  current lane
step  out  1  one-cycle pulse on each game step
crash  out  1  one-cycle pulse, coincident with step, when a collision is charged
immune  out  1  high while in IMMUNE
lives_left  out  4  remaining lives
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset values (async, rst_n low):
  - position = START_POS
  - lives_left = LIVES
  - state = ALIVE
  - tick counter, immunity counter and move latch = 0
  - step, crash, immune and game_over = 0
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - The cycle where it equals TICK_DIV-1 is the step cycle.
  - step is registered and goes high the cycle after the step cycle, together with all other updated outputs.
  - In GAME_OVER the divider keeps running but step is suppressed.
- Move latch:
  - The first move_req of 10 or 01 between steps is latched.
  - Later requests are ignored until the next step.
  - 11 is never latched.
- Effective move on the step cycle:
  - Use the latch if it is non-zero.
  - Otherwise use move_req if it is 10 or 01.
  - Otherwise the move is up.
  - The latch is cleared on every step cycle.
- Target lane:
  - Left gives p+1, or p if p = LANES-1.
  - Right gives p-1, or p if p = 0.
  - Up gives p.
- Collision test, evaluated in ALIVE only:
  - Up: collision if next_row[p].
  - Left/right, not at the edge: collision if next_row[target] OR head_row[target].
  - Left/right, at the edge: collision if next_row[p].
- States:
  - ALIVE, no collision: position <= target.
  - ALIVE, collision:
    - position held, crash pulses, lives_left decrements.
    - If the new lives_left = 0, go to GAME_OVER.
    - Otherwise go to IMMUNE with the immunity counter = IMMUNE_TICKS.
  - IMMUNE:
    - position <= target with no collision test.
    - The immunity counter decrements on each step.
    - The step that brings it to 0 returns to ALIVE; that step's move is still resolved as immune.
    - Exactly IMMUNE_TICKS steps are immune.
  - GAME_OVER:
    - position, lives_left and move latch are frozen; move_req is ignored.
    - restart = 1 for one cycle gives, on the next cycle: ALIVE, lives_left = LIVES, position = START_POS, tick counter = 0, latch cleared.
    - restart outside GAME_OVER has no effect.
- Simultaneous events:
  - restart in the same cycle as a would-be step: restart wins.
  - move_req in the step cycle with an empty latch: used for that step, not carried forward.
- rst_n asserted mid-step or mid-immunity aborts immediately to the reset values.
- Widths:
  - position is exactly $clog2(LANES) bits.
  - lives_left arithmetic must never underflow; decrement happens only from a non-zero value.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Free drive (TICK_DIV=4, LANES=6, rows all 0):
  - Stimulus: pulse move_req=10 for 1 cycle, then idle.
  - Required: step every 4 cycles; after the first step position 2→3; the second step leaves it at 3.
- Edge clamp and edge crash:
  - Stimulus: position 5, move left, next_row=6'b100000.
  - Required: crash=1, lives 3→2, position stays 5, immune=1.
- Side collision via head_row (position 2):
  - Stimulus: move right, head_row=6'b000010, next_row=0.
  - Required: crash pulses, position stays 2.
  - Stimulus: same with head_row=0.
  - Required: position 1, no crash.
- Immunity window (IMMUNE_TICKS=3):
  - Stimulus: crash, then next_row all 1s for 4 steps.
  - Required: no crash on steps 1-3, immune drops after step 3, crash on step 4, lives 2→1.
- Game over and restart (LIVES=1):
  - Stimulus: a single crash.
  - Required: game_over=1, lives_left=0, step stops, move_req ignored.
  - Stimulus: restart pulse.
  - Required: position=2, lives_left=1, game_over=0, first step exactly TICK_DIV cycles later.
- Request arbitration and reset:
  - Stimulus: move_req 01 then 10 within one step period.
  - Required: only the right move is applied.
  - Stimulus: rst_n low mid-period.
  - Required: all outputs at reset values immediately, latch cleared.
